// File: rtl/factor_streamer_pkg.sv
// Shared constants and FSM encoding for the factor streaming path.
// The factorizer and the formatting stage use the same values.
package factor_streamer_pkg;

  localparam int NUMBER_WIDTH_D = 8;
  localparam int FACTOR_BITS_D  = 18;
  localparam int MIN_FACTOR_D   = 2;
  localparam int FW_D           = 5;
  localparam int INDEX_W        = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/factor_lsb_enc.sv
// Lowest-set-bit encoder over the factor mask, with "any" and "at most one bit" flags.
module factor_lsb_enc #(
  parameter int FACTOR_BITS = 18
) (
  input  logic [FACTOR_BITS-1:0] mask,
  output logic [4:0]             pos,
  output logic                   any,
  output logic                   single
);

  // Scan from the top so the last match is the lowest set bit.
  always_comb begin
    pos = '0;
    for (int k = FACTOR_BITS - 1; k >= 0; k--) begin
      if (mask[k]) pos = 5'(k);
    end
  end

  assign any    = |mask;
  assign single = (mask & (mask - FACTOR_BITS'(1))) == '0;

endmodule

// File: rtl/factor_streamer.sv
// Turns one captured divisibility vector into a stream of factor beats,
// ascending, or a single "no factor" beat when the vector is empty.
module factor_streamer
  import factor_streamer_pkg::*;
#(
  parameter int NUMBER_WIDTH = NUMBER_WIDTH_D,
  parameter int FACTOR_BITS  = FACTOR_BITS_D,
  parameter int MIN_FACTOR   = MIN_FACTOR_D,
  parameter int FW           = FW_D
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUMBER_WIDTH-1:0] in_number,
  input  logic [FACTOR_BITS-1:0]  in_factors,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [FW-1:0]           out_factor,
  output logic [NUMBER_WIDTH-1:0] out_number,
  output logic [INDEX_W-1:0]      out_index,
  output logic                    out_last,
  output logic                    out_none,
  output state_t                  state_dbg
);

  state_t                  state;
  logic [FACTOR_BITS-1:0]  mask;
  logic [NUMBER_WIDTH-1:0] num;
  logic [INDEX_W-1:0]      index;
  logic [4:0]              lsb_pos;
  logic                    mask_any;
  logic                    mask_single;

  factor_lsb_enc #(.FACTOR_BITS(FACTOR_BITS)) u_lsb_enc (
    .mask   (mask),
    .pos    (lsb_pos),
    .any    (mask_any),
    .single (mask_single)
  );

  // A transfer happens on a rising edge where valid && ready; a producer holds
  // its payload stable and keeps valid high until that edge. Both readies here
  // depend only on state, so there is no input-to-output combinational path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      mask  <= '0;
      num   <= '0;
      index <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            mask  <= in_factors;
            num   <= in_number;
            index <= '0;
            state <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            mask  <= mask & (mask - FACTOR_BITS'(1));
            index <= index + INDEX_W'(1);
            if (mask_single) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = (state == ST_IDLE);
  assign out_valid  = (state == ST_EMIT);
  assign out_factor = (out_valid && mask_any) ? (FW'(lsb_pos) + FW'(MIN_FACTOR)) : '0;
  assign out_last   = out_valid && mask_single;
  assign out_none   = out_valid && !mask_any;
  assign out_number = num;
  assign out_index  = index;
  assign state_dbg  = state;

endmodule

// File: tb/tb_factor_streamer.sv
// Directed bench for factor_streamer: expected beats are queued and compared as the stream drains.
module tb_factor_streamer;
  import factor_streamer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_number;
  logic [17:0] in_factors;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_factor;
  logic [7:0]  out_number;
  logic [4:0]  out_index;
  logic        out_last;
  logic        out_none;
  state_t      state_dbg;

  int checks   = 0;
  int failures = 0;

  // Packed expectation: {last, none, index[4:0], factor[4:0]}
  logic [11:0] exp_q[$];
  logic [7:0]  exp_num;

  factor_streamer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_number  (in_number),
    .in_factors (in_factors),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_factor (out_factor),
    .out_number (out_number),
    .out_index  (out_index),
    .out_last   (out_last),
    .out_none   (out_none),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] beat(input bit last, input bit none, input int idx, input int fac);
    return {last, none, 5'(idx), 5'(fac)};
  endfunction

  // driver: present one vector, then confirm first beat one cycle after capture
  task automatic send(input logic [7:0] num, input logic [17:0] fac);
    int budget = 50;
    out_ready = 1'b0;
    @(negedge clk);
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!in_ready) check("send_wait_ready", in_ready, 1);
    in_valid   = 1'b1;
    in_number  = num;
    in_factors = fac;
    exp_num    = num;
    @(negedge clk);
    in_valid = 1'b0;
    check("first_beat_latency", out_valid, 1);
  endtask

  // scoreboard: consume beats, optionally stalling on one index
  task automatic drain(input int stall_idx, input int stall_cycles);
    int budget = 400;
    int stalls = 0;
    logic [11:0] e;
    while (exp_q.size() > 0 && budget > 0) begin
      budget--;
      if (!out_valid) begin
        check("out_valid_mid_frame", out_valid, 1);
        break;
      end
      e = exp_q[0];
      check("factor", out_factor, e[4:0]);
      check("index", out_index, e[9:5]);
      check("last", out_last, e[11]);
      check("none", out_none, e[10]);
      check("number", out_number, exp_num);
      check("in_ready_busy", in_ready, 0);
      if (out_index == 5'(stall_idx) && stalls < stall_cycles) begin
        out_ready = 1'b0;
        stalls++;
      end else begin
        out_ready = 1'b1;
        void'(exp_q.pop_front());
      end
      @(negedge clk);
    end
    if (exp_q.size() != 0) check("drain_beats_left", exp_q.size(), 0);
    exp_q.delete();
    check("idle_out_valid", out_valid, 0);
    check("idle_in_ready", in_ready, 1);
    check("idle_state", state_dbg, ST_IDLE);
  endtask

  initial begin
    int budget;
    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    in_number  = '0;
    in_factors = '0;
    exp_num    = '0;
    #2 reset = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_factor", out_factor, 0);
    check("rst_number", out_number, 0);
    check("rst_index", out_index, 0);
    check("rst_last", out_last, 0);
    check("rst_none", out_none, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // 1: 12 -> 2,3,4,6,12
    exp_q.push_back(beat(0, 0, 0, 2));
    exp_q.push_back(beat(0, 0, 1, 3));
    exp_q.push_back(beat(0, 0, 2, 4));
    exp_q.push_back(beat(0, 0, 3, 6));
    exp_q.push_back(beat(1, 0, 4, 12));
    send(8'd12, 18'h00417);
    drain(-1, 0);

    // 2: empty vector -> single none beat
    exp_q.push_back(beat(1, 1, 0, 0));
    send(8'd23, 18'h00000);
    drain(-1, 0);

    // 3: all bits -> 2..19
    for (int k = 0; k < 18; k++) exp_q.push_back(beat(k == 17, 0, k, k + 2));
    send(8'd0, 18'h3FFFF);
    drain(-1, 0);

    // 4: stall 5 cycles on the third beat (factor 4, index 2)
    exp_q.push_back(beat(0, 0, 0, 2));
    exp_q.push_back(beat(0, 0, 1, 3));
    exp_q.push_back(beat(0, 0, 2, 4));
    exp_q.push_back(beat(0, 0, 3, 6));
    exp_q.push_back(beat(1, 0, 4, 12));
    send(8'd12, 18'h00417);
    drain(2, 5);

    // 5: in_valid held during a frame; 35 (bits 3,5 -> 5,7) captured after it
    exp_q.push_back(beat(0, 0, 0, 2));
    exp_q.push_back(beat(0, 0, 1, 3));
    exp_q.push_back(beat(0, 0, 2, 4));
    exp_q.push_back(beat(0, 0, 3, 6));
    exp_q.push_back(beat(1, 0, 4, 12));
    send(8'd12, 18'h00417);
    in_valid   = 1'b1;
    in_number  = 8'd35;
    in_factors = 18'h00028;
    drain(-1, 0);
    exp_num = 8'd35;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("held_capture_valid", out_valid, 1);
    exp_q.push_back(beat(0, 0, 0, 5));
    exp_q.push_back(beat(1, 0, 1, 7));
    drain(-1, 0);

    // 6: async reset during second beat of case 1, then 10 -> 2,5,10
    send(8'd12, 18'h00417);
    out_ready = 1'b1;
    budget = 20;
    while (out_index != 5'd1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("reach_beat2", out_index, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_index", out_index, 0);
    check("arst_number", out_number, 0);
    check("arst_factor", out_factor, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_no_beat", out_valid, 0);
    exp_q.push_back(beat(0, 0, 0, 2));
    exp_q.push_back(beat(0, 0, 1, 5));
    exp_q.push_back(beat(1, 0, 2, 10));
    send(8'd10, 18'h00109);
    drain(-1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
